// File: rtl/decred_result_arbiter.sv
// -----------------------------------------------------------------------------
// decred_result_arbiter
//
// Purpose:
//   Several hash macros share one readout bus. When a macro flags a result,
//   this block grants it (round-robin among eligible macros), reads its result
//   record byte by byte over the shared bus, stores each byte tagged with the
//   macro id into an output FIFO, then pulses a per-macro clear to acknowledge
//   the drained record. A burst only starts when the FIFO can hold a whole
//   record, so the FIFO never overflows and a started burst always completes.
//
// Ports:
//   i_clk              single clock for all state
//   i_reset            asynchronous, active-high reset
//   i_enable           permits new bursts to start
//   i_macro_mask       per-macro eligibility (1 = may be serviced)
//   i_data_available   per-macro result-ready flags
//   i_data_from_hash   shared readout byte, valid one cycle after the address
//   o_macro_rd_select  one-hot read select of the granted macro, 0 when idle
//   o_hash_addr        readout address within the macro
//   o_macro_clr        one-cycle one-hot pulse acknowledging a drained record
//   o_out_valid        FIFO holds at least one entry
//   i_out_ready        pop request; honoured only while o_out_valid is high
//   o_out_data         head entry byte
//   o_out_id           head entry macro id
//   o_out_last         head entry is the final byte of its record
//   o_fifo_level       number of occupied FIFO entries
//   o_busy             a burst is in progress
// -----------------------------------------------------------------------------
module decred_result_arbiter #(
    parameter int                NUM_MACROS   = 4,
    parameter int                ADDR_W       = 6,
    parameter int                DATA_W       = 8,
    parameter logic [ADDR_W-1:0] RESULT_BASE  = 6'h20,
    parameter int                RESULT_BYTES = 4,
    parameter int                FIFO_DEPTH   = 16,
    localparam int               ID_W         = (NUM_MACROS > 1) ? $clog2(NUM_MACROS) : 1,
    localparam int               LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [NUM_MACROS-1:0] i_macro_mask,
    input  logic [NUM_MACROS-1:0] i_data_available,
    input  logic [DATA_W-1:0]     i_data_from_hash,
    output logic [NUM_MACROS-1:0] o_macro_rd_select,
    output logic [ADDR_W-1:0]     o_hash_addr,
    output logic [NUM_MACROS-1:0] o_macro_clr,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_W-1:0]     o_out_data,
    output logic [ID_W-1:0]       o_out_id,
    output logic                  o_out_last,
    output logic [LVL_W-1:0]      o_fifo_level,
    output logic                  o_busy
);

    localparam int CNT_W = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RESULT_BYTES - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_CLEAR
    } state_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic              last;
    } entry_t;

    function automatic logic [NUM_MACROS-1:0] onehot(input logic [ID_W-1:0] id);
        return NUM_MACROS'(1) << id;
    endfunction

    // ---------------------------------------------------------------- state
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    // Macro of the current burst; between bursts it is the last grant, which
    // is where the next round-robin search starts from.
    logic [ID_W-1:0]       r_grant;
    logic [NUM_MACROS-1:0] r_rd_select;
    logic [ADDR_W-1:0]     r_hash_addr;
    logic [NUM_MACROS-1:0] r_macro_clr;
    logic                  r_busy;

    entry_t                r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;

    // ---------------------------------------------------------------- next
    state_t                w_state_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [ID_W-1:0]       w_grant_next;
    logic [NUM_MACROS-1:0] w_rd_select_next;
    logic [ADDR_W-1:0]     w_hash_addr_next;
    logic [NUM_MACROS-1:0] w_macro_clr_next;

    logic [NUM_MACROS-1:0] w_eligible;
    logic                  w_room;
    logic                  w_found;
    logic [ID_W-1:0]       w_idx;
    logic [ID_W-1:0]       w_grant_sel;
    logic                  w_push;
    logic                  w_push_last;
    logic                  w_pop;
    entry_t                w_push_entry;
    entry_t                w_head;

    assign w_eligible = i_data_available & i_macro_mask;
    // Space is judged on the registered level only; a pop in the same cycle
    // is not credited, which is conservative and keeps the check simple.
    assign w_room     = (FIFO_DEPTH - int'(r_level)) >= RESULT_BYTES;

    // Round-robin: first eligible macro at or after last_grant+1, wrapping.
    always_comb begin
        w_found     = 1'b0;
        w_idx       = '0;
        w_grant_sel = r_grant;
        for (int i = 1; i <= NUM_MACROS; i++) begin
            w_idx = ID_W'((int'(r_grant) + i) % NUM_MACROS);
            if (!w_found && w_eligible[w_idx]) begin
                w_found     = 1'b1;
                w_grant_sel = w_idx;
            end
        end
    end

    // Next-state logic. Output values are computed for the state being
    // entered and then registered, so every bus-side output is a flop.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_grant_next     = r_grant;
        w_rd_select_next = '0;
        w_hash_addr_next = '0;
        w_macro_clr_next = '0;
        w_push           = 1'b0;
        w_push_last      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (i_enable && w_found && w_room) begin
                    w_state_next     = ST_READ;
                    w_cnt_next       = '0;
                    w_grant_next     = w_grant_sel;
                    w_rd_select_next = onehot(w_grant_sel);
                    w_hash_addr_next = RESULT_BASE;
                end
            end

            ST_READ: begin
                w_rd_select_next = onehot(r_grant);
                // Bus data lags the address by one cycle: the byte for
                // address k arrives while address k+1 is driven.
                w_push = (r_cnt != '0);
                if (r_cnt == LAST_CNT) begin
                    w_state_next     = ST_DRAIN;
                    w_hash_addr_next = RESULT_BASE + ADDR_W'(r_cnt);
                end else begin
                    w_cnt_next       = r_cnt + CNT_W'(1);
                    w_hash_addr_next = RESULT_BASE + ADDR_W'(r_cnt) + ADDR_W'(1);
                end
            end

            // Extra cycle that only collects the final lagging byte.
            ST_DRAIN: begin
                w_push           = 1'b1;
                w_push_last      = 1'b1;
                w_macro_clr_next = onehot(r_grant);
                w_state_next     = ST_CLEAR;
            end

            ST_CLEAR: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_grant     <= ID_W'(NUM_MACROS - 1);
            r_rd_select <= '0;
            r_hash_addr <= '0;
            r_macro_clr <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_grant     <= w_grant_next;
            r_rd_select <= w_rd_select_next;
            r_hash_addr <= w_hash_addr_next;
            r_macro_clr <= w_macro_clr_next;
            r_busy      <= (w_state_next != ST_IDLE);
        end
    end

    // ---------------------------------------------------------------- FIFO
    assign w_pop        = (r_level != '0) && i_out_ready;
    assign w_push_entry = '{id: r_grant, data: i_data_from_hash, last: w_push_last};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // level define which entries are meaningful, and empty reads are masked.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    // ---------------------------------------------------------------- outputs
    assign o_macro_rd_select = r_rd_select;
    assign o_hash_addr       = r_hash_addr;
    assign o_macro_clr       = r_macro_clr;
    assign o_busy            = r_busy;
    assign o_fifo_level      = r_level;
    assign o_out_valid       = (r_level != '0);
    // Head fields read as zero while empty so stale storage never shows.
    assign o_out_data        = o_out_valid ? w_head.data : '0;
    assign o_out_id          = o_out_valid ? w_head.id   : '0;
    assign o_out_last        = o_out_valid ? w_head.last : 1'b0;

endmodule

// File: doc/decred_result_arbiter.md
DECRED_RESULT_ARBITER -- requirements
Module: decred_result_arbiter

Interface
REQ-001 Parameter NUM_MACROS, default 4, number of hash macros sharing the readout bus.
REQ-002 Parameter ADDR_W, default 6, width of HASH_ADDR.
REQ-003 Parameter DATA_W, default 8, width of the readout byte.
REQ-004 Parameter RESULT_BASE, default 6'h20, first macro address of a result record.
REQ-005 Parameter RESULT_BYTES, default 4, bytes per result record (1..2^ADDR_W-RESULT_BASE).
REQ-006 Parameter FIFO_DEPTH, default 16, output FIFO entries (power of 2, >= RESULT_BYTES).
REQ-007 ID_W = max(1, clog2(NUM_MACROS)); LVL_W = clog2(FIFO_DEPTH)+1.
REQ-008 CLK  in  1  single clock for all state.
REQ-009 RESET  in  1  asynchronous, active-high reset.
REQ-010 ENABLE  in  1  permits new bursts to start.
REQ-011 MACRO_MASK  in  NUM_MACROS  1 = macro eligible for service.
REQ-012 DATA_AVAILABLE  in  NUM_MACROS  per-macro result-ready flags.
REQ-013 DATA_FROM_HASH  in  DATA_W  shared readout bus, valid 1 cycle after address.
REQ-014 MACRO_RD_SELECT  out  NUM_MACROS  one-hot read select, 0 when idle.
REQ-015 HASH_ADDR  out  ADDR_W  readout address.
REQ-016 MACRO_CLR  out  NUM_MACROS  one-cycle one-hot pulse acknowledging a drained record.
REQ-017 OUT_VALID / OUT_READY  out / in  1  FIFO pop handshake.
REQ-018 OUT_DATA  out  DATA_W;  OUT_ID  out  ID_W;  OUT_LAST  out  1  head-entry fields.
REQ-019 FIFO_LEVEL  out  LVL_W  occupied entries;  BUSY  out  1  FSM not IDLE.

Function
REQ-020 FSM states IDLE, READ, DRAIN, CLEAR; all outputs registered or FIFO-derived.
REQ-021 IDLE->READ when ENABLE=1, (DATA_AVAILABLE & MACRO_MASK)!=0 and (FIFO_DEPTH-FIFO_LEVEL)>=RESULT_BYTES; else stay.
REQ-022 Grant: round-robin, search from (last_grant+1) mod NUM_MACROS upward, first eligible wins; last_grant updates on grant.
REQ-023 READ lasts RESULT_BYTES cycles; cycle k drives HASH_ADDR=RESULT_BASE+k, MACRO_RD_SELECT=one-hot(grant).
REQ-024 DRAIN lasts 1 cycle, holds MACRO_RD_SELECT, HASH_ADDR holds last address.
REQ-025 DATA_FROM_HASH sampled in cycles READ[1..]..DRAIN; each sample pushed as {grant id, byte, last}, last=1 only for byte RESULT_BYTES-1.
REQ-026 CLEAR lasts 1 cycle: MACRO_CLR=one-hot(grant), MACRO_RD_SELECT=0, HASH_ADDR=0; then IDLE.
REQ-027 Burst length RESULT_BYTES+2 cycles from leaving IDLE to re-entering IDLE.
REQ-028 In IDLE MACRO_RD_SELECT=0, HASH_ADDR=0, MACRO_CLR=0.
REQ-029 Started bursts always complete: ENABLE, MACRO_MASK or DATA_AVAILABLE changes mid-burst ignored.
REQ-030 FIFO cannot overflow (REQ-021 guarantee); push and pop in same cycle leave FIFO_LEVEL unchanged.
REQ-031 OUT_VALID=1 iff FIFO_LEVEL>0; OUT_DATA/OUT_ID/OUT_LAST show head entry; pop on OUT_VALID&OUT_READY.
REQ-032 OUT_READY with empty FIFO ignored; no underflow.
REQ-033 Record bytes from one burst are contiguous in FIFO, in address order.
REQ-034 Full FIFO stalls only burst start; OUT_READY held 0 indefinitely is legal.

Reset
REQ-035 RESET=1 asynchronously forces IDLE, FIFO empty, last_grant=NUM_MACROS-1, all outputs 0 (OUT_VALID=0, FIFO_LEVEL=0, BUSY=0).
REQ-036 Reset mid-burst aborts without MACRO_CLR pulse; partial bytes discarded.
REQ-037 First cycle after RESET deasserts may grant if REQ-021 holds.

Verification
REQ-038 Defaults, DATA_AVAILABLE=4'b0100, mask 4'hF, macro2 returns addr^8'hA5 -> RD_SELECT=4'b0100, addrs 0x20..0x23, FIFO gets 85,84,87,86 with ID=2, LAST on 4th, MACRO_CLR=4'b0100 at cycle 6.
REQ-039 DATA_AVAILABLE=4'hF held, OUT_READY=1 -> grant order 0,1,2,3,0; each burst 6 cycles.
REQ-040 MACRO_MASK=4'b1101, DATA_AVAILABLE=4'b0010 -> no grant, BUSY=0 for 50 cycles.
REQ-041 OUT_READY=0, all available -> 4 bursts fill FIFO_LEVEL=16, no 5th burst; one pop round of 4 enables next burst.
REQ-042 RESET pulsed in READ cycle 2 -> outputs 0 immediately, FIFO_LEVEL=0, no MACRO_CLR seen.
REQ-043 ENABLE dropped in READ cycle 1 -> burst completes with 4 bytes and CLR; no new burst while ENABLE=0.
